muldiv_ctrl: RTL and testbench

- Iterative multiply/divide sequencer placed beside the ALU in the EX stage.
- Executes MULT/MULTU/DIV/DIVU in 34 cycles using one shared 33-bit add/sub, and owns the HI/LO registers; also handles MTHI/MTLO writes.
- Drives a stall to the hazard logic while a request cannot be accepted.
- The EX-stage mux reads HI/LO for MFHI/MFLO.

---
 rtl/muldiv_ctrl_pkg.sv | 23 ++
 rtl/muldiv_ctrl_addsub.sv | 23 ++
 rtl/muldiv_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared encodings for the multiply/divide sequencer
// Contents: MDOp operation codes, FSM state codes, op-class helper.
package muldiv_ctrl_pkg;

  localparam logic [2:0] MDOP_MULTU = 3'd0;
  localparam logic [2:0] MDOP_MULT  = 3'd1;
  localparam logic [2:0] MDOP_DIVU  = 3'd2;
  localparam logic [2:0] MDOP_DIV   = 3'd3;
  localparam logic [2:0] MDOP_MTHI  = 3'd4;
  localparam logic [2:0] MDOP_MTLO  = 3'd5;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_RUN  = 2'd1;
  localparam logic [1:0] MD_FIX  = 2'd2;
  localparam logic [1:0] MD_DONE = 2'd3;

  // Ops that occupy the iterative datapath (as opposed to MTHI/MTLO/no-ops).
  function automatic logic mdop_is_muldiv(input logic [2:0] op);
    return (op == MDOP_MULTU) || (op == MDOP_MULT) ||
           (op == MDOP_DIVU)  || (op == MDOP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_addsub.sv
// rtl/muldiv_ctrl_addsub.sv - combinational add/sub shared by multiply and divide
// Ports:
//   a, b  [W-1:0]  operands
//   sub            1 = a - b, 0 = a + b
//   sum   [W-1:0]  result
//   carry          carry out; for subtract, 1 means a >= b (no borrow)
module md_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] full;

  assign full  = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, sub};
  assign sum   = full[W-1:0];
  assign carry = full[W];

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, MDOp       request valid (held until accepted) and op code
//   DataIn1, DataIn2  rs / rt operands
//   cancel            pipeline flush, aborts RUN/FIX
//   busy, stall       sequencer occupied; request blocked this cycle
//   done, div0        commit pulse; sticky divide-by-zero flag
//   HI, LO            result registers
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] DataIn1,
  input  logic [WIDTH-1:0] DataIn2,
  input  logic             cancel,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // acc: product high half / partial remainder; shf: multiplier / quotient.
  logic [WIDTH-1:0] acc_q, acc_d, shf_q, shf_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] dvd_q, dvd_d;     // raw rs value, returned on divide by zero
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             op_div_q, op_div_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic             dzero_q, dzero_d, div0_q, div0_d;

  logic             accept, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   div_shift, as_a, as_b, as_sum;
  logic             as_sub, as_carry;

  assign busy   = (state_q == MD_RUN) || (state_q == MD_FIX);
  assign stall  = start & busy & ~cancel;
  assign done   = (state_q == MD_DONE);
  assign div0   = div0_q;
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign accept = start & ~busy & ~cancel;

  assign op_signed = (MDOp == MDOP_MULT) || (MDOp == MDOP_DIV);
  assign a_neg     = op_signed & DataIn1[WIDTH-1];
  assign b_neg     = op_signed & DataIn2[WIDTH-1];
  assign mag_a     = a_neg ? -DataIn1 : DataIn1;
  assign mag_b     = b_neg ? -DataIn2 : DataIn2;

  // Divide step shifts the next dividend bit (quotient register MSB) into the remainder.
  assign div_shift = {acc_q, shf_q[WIDTH-1]};

  always_comb begin
    if (op_div_q) begin
      as_a   = div_shift;
      as_b   = {1'b0, opnd_q};
      as_sub = 1'b1;
    end else begin
      as_a   = {1'b0, acc_q};
      as_b   = shf_q[0] ? {1'b0, opnd_q} : '0;
      as_sub = 1'b0;
    end
  end

  md_addsub #(.W(WIDTH + 1)) u_addsub (
    .a    (as_a),
    .b    (as_b),
    .sub  (as_sub),
    .sum  (as_sum),
    .carry(as_carry)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    shf_d    = shf_q;
    opnd_d   = opnd_q;
    dvd_d    = dvd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    op_div_d = op_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dzero_d  = dzero_q;
    div0_d   = div0_q;

    case (state_q)
      MD_RUN: begin
        if (cancel) begin
          state_d = MD_IDLE;
        end else begin
          if (op_div_q) begin
            // Restoring step: keep the difference only when it did not borrow.
            acc_d = as_carry ? as_sum[WIDTH-1:0] : div_shift[WIDTH-1:0];
            shf_d = {shf_q[WIDTH-2:0], as_carry};
          end else begin
            acc_d = as_sum[WIDTH:1];
            shf_d = {as_sum[0], shf_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        if (cancel) begin
          state_d = MD_IDLE;
        end else begin
          state_d = MD_DONE;
          if (op_div_q) begin
            if (dzero_q) begin
              acc_d  = dvd_q;
              shf_d  = '1;
              div0_d = 1'b1;
            end else begin
              if (qneg_q) shf_d = -shf_q;
              if (rneg_q) acc_d = -acc_q;
            end
          end else if (qneg_q) begin
            {acc_d, shf_d} = -{acc_q, shf_q};
          end
        end
      end
      MD_DONE: begin
        // Commit is not cancellable: the instruction has already left EX.
        hi_d    = acc_q;
        lo_d    = shf_q;
        state_d = MD_IDLE;
      end
      default: ;
    endcase

    // Placed after the commit so an MTHI/MTLO accepted in DONE overrides it.
    if (accept) begin
      if (mdop_is_muldiv(MDOp)) begin
        op_div_d = (MDOp == MDOP_DIVU) || (MDOp == MDOP_DIV);
        acc_d    = '0;
        shf_d    = op_div_d ? mag_a : mag_b;
        opnd_d   = op_div_d ? mag_b : mag_a;
        dvd_d    = DataIn1;
        qneg_d   = a_neg ^ b_neg;
        rneg_d   = a_neg;
        dzero_d  = (DataIn2 == '0);
        div0_d   = 1'b0;
        cnt_d    = '0;
        state_d  = MD_RUN;
      end else if (MDOp == MDOP_MTHI) begin
        hi_d   = DataIn1;
        div0_d = 1'b0;
      end else if (MDOp == MDOP_MTLO) begin
        lo_d   = DataIn1;
        div0_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      shf_q    <= '0;
      opnd_q   <= '0;
      dvd_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      op_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dzero_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      shf_q    <= shf_d;
      opnd_q   <= opnd_d;
      dvd_q    <= dvd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      op_div_q <= op_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dzero_q  <= dzero_d;
      div0_q   <= div0_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;

  localparam logic [2:0] OP_MULTU = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic        clk = 1'b0;
  logic        rst, start, cancel;
  logic [2:0]  MDOp;
  logic [31:0] DataIn1, DataIn2;
  logic        busy, stall, done, div0;
  logic [31:0] HI, LO;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .MDOp   (MDOp),
    .DataIn1(DataIn1),
    .DataIn2(DataIn2),
    .cancel (cancel),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .div0   (div0),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural result of one mul/div op, from plain 64-bit arithmetic.
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output logic z);
    longint      sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z  = 1'b0;
    h  = '0;
    l  = '0;
    case (op)
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      OP_MULT:  begin p = sa * sb;                 h = p[63:32]; l = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          h = a; l = 32'hFFFF_FFFF; z = 1'b1;
        end else if (op == OP_DIVU) begin
          l = a / b; h = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          l = q[31:0]; h = r[31:0];
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    logic        ez;
    int          lat, busy_n;
    bit          seen;
    ref_op(op, a, b, eh, el, ez);
    @(negedge clk);
    start = 1'b1; MDOp = op; DataIn1 = a; DataIn2 = b;
    check("busy_at_accept", {63'b0, busy}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("div0_clear_on_accept", {63'b0, div0}, 64'd0);
    lat = 1; busy_n = 0; seen = 0;
    while (!seen && lat < 100) begin
      if (done) seen = 1;
      else begin
        if (busy) busy_n++;
        @(negedge clk);
        lat++;
      end
    end
    check("done_latency", 64'(lat), 64'd34);
    check("busy_cycles", 64'(busy_n), 64'd33);
    check("div0_with_done", {63'b0, div0}, {63'b0, ez});
    @(negedge clk);
    check("hi_result", {32'b0, HI}, {32'b0, eh});
    check("lo_result", {32'b0, LO}, {32'b0, el});
    check("div0_sticky", {63'b0, div0}, {63'b0, ez});
    hi_m = eh; lo_m = el;
  endtask

  initial begin
    logic [31:0] eh, el;
    logic        ez;
    int          guard, dn;

    rst = 1'b1; start = 1'b0; cancel = 1'b0; MDOp = '0; DataIn1 = '0; DataIn2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_hi", {32'b0, HI}, 64'd0);
    check("rst_lo", {32'b0, LO}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_div0", {63'b0, div0}, 64'd0);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi", {32'b0, HI}, 64'h0000_0000_FFFF_FFFE);
    run_op(OP_MULT, 32'hFFFF_FFF9, 32'd3);
    check("mult_neg_lo", {32'b0, LO}, 64'h0000_0000_FFFF_FFEB);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_hi", {32'b0, HI}, 64'h0000_0000_FFFF_FFFF);
    run_op(OP_DIVU, 32'd100, 32'd7);
    check("divu_lo", {32'b0, LO}, 64'd14);
    run_op(OP_DIVU, 32'h0000_1234, 32'd0);
    check("divu0_hi", {32'b0, HI}, 64'h1234);
    run_op(OP_MULTU, 32'd6, 32'd7);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'h8000_0005, 32'd0);

    // No-op codes leave everything alone.
    for (int c = 6; c < 8; c++) begin
      @(negedge clk);
      start = 1'b1; MDOp = 3'(c); DataIn1 = 32'h1357_9BDF;
      @(negedge clk);
      start = 1'b0;
      check("noop_busy", {63'b0, busy}, 64'd0);
      check("noop_hi", {32'b0, HI}, {32'b0, hi_m});
      check("noop_lo", {32'b0, LO}, {32'b0, lo_m});
      @(negedge clk);
      check("noop_done", {63'b0, done}, 64'd0);
    end

    // MTLO / MTHI from IDLE.
    @(negedge clk);
    start = 1'b1; MDOp = OP_MTLO; DataIn1 = 32'h5555_1234;
    @(negedge clk);
    start = 1'b0; lo_m = 32'h5555_1234;
    check("mtlo_lo", {32'b0, LO}, {32'b0, lo_m});
    check("mtlo_busy", {63'b0, busy}, 64'd0);
    start = 1'b1; MDOp = OP_MTHI; DataIn1 = 32'h0BAD_F00D;
    @(negedge clk);
    start = 1'b0; hi_m = 32'h0BAD_F00D;
    check("mthi_hi", {32'b0, HI}, {32'b0, hi_m});

    // MTHI held while a multiply is running: stalls, then wins over the commit.
    ref_op(OP_MULTU, 32'h0001_0001, 32'h0003_0000, eh, el, ez);
    @(negedge clk);
    start = 1'b1; MDOp = OP_MULTU; DataIn1 = 32'h0001_0001; DataIn2 = 32'h0003_0000;
    @(negedge clk);
    MDOp = OP_MTHI; DataIn1 = 32'hAAAA_0000;
    guard = 0;
    while (!done && guard < 100) begin
      check("mthi_stall", {63'b0, stall}, 64'd1);
      check("mthi_hi_hold", {32'b0, HI}, {32'b0, hi_m});
      @(negedge clk);
      guard++;
    end
    check("mthi_wait_cycles", 64'(guard), 64'd33);
    check("mthi_stall_done", {63'b0, stall}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    hi_m = 32'hAAAA_0000; lo_m = el;
    check("mthi_after_commit_hi", {32'b0, HI}, {32'b0, hi_m});
    check("mthi_after_commit_lo", {32'b0, LO}, {32'b0, lo_m});
    check("mthi_no_run", {63'b0, busy}, 64'd0);

    // cancel at T+10 of a MULTU.
    @(negedge clk);
    start = 1'b1; MDOp = OP_MULTU; DataIn1 = 32'hFFFF_FFFF; DataIn2 = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", {63'b0, busy}, 64'd0);
    dn = 0;
    repeat (30) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("cancel_no_done", 64'(dn), 64'd0);
    check("cancel_hi", {32'b0, HI}, {32'b0, hi_m});
    check("cancel_lo", {32'b0, LO}, {32'b0, lo_m});

    // cancel together with start in IDLE.
    start = 1'b1; cancel = 1'b1; MDOp = OP_MTHI; DataIn1 = 32'hDEAD_BEEF;
    check("cancel_start_stall", {63'b0, stall}, 64'd0);
    @(negedge clk);
    MDOp = OP_MULTU;
    check("cancel_start_hi", {32'b0, HI}, {32'b0, hi_m});
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel_start_busy", {63'b0, busy}, 64'd0);

    // rst at T+20 of a DIV.
    @(negedge clk);
    start = 1'b1; MDOp = OP_DIV; DataIn1 = 32'hFFFF_0000; DataIn2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hi_m = '0; lo_m = '0;
    check("midrst_hi", {32'b0, HI}, 64'd0);
    check("midrst_lo", {32'b0, LO}, 64'd0);
    check("midrst_busy", {63'b0, busy}, 64'd0);
    run_op(OP_MULTU, 32'd3, 32'd5);
    check("post_rst_lo", {32'b0, LO}, 64'd15);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 3)), pick(), pick());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
